ppa_share_arb: RTL and testbench

Two-requester arbiter that time-shares one external 32-bit parallel-prefix adder between two clients.
- Accepts add/subtract requests over valid/ready handshakes and picks one requester per operation.
- Drives the adder operands and carry-in for one cycle, registers sum/ovf/cout, and returns the result to the owning requester over a valid/ready response channel.
- Sits between the ALU-side clients and the shared adder instance.

---
 rtl/ppa_share_arb.sv | 175 +++++++++++++++++
 tb/tb_ppa_share_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppa_share_arb.sv
// Two-requester front end that time-shares one external 32-bit prefix adder.
// Each operation is accepted, computed and returned as IDLE -> COMPUTE -> RESP -> IDLE.
module ppa_share_arb #(
   parameter int WIDTH     = 32,
   parameter bit PRIO_MODE = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   // requester 0
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic             r0_sub,
   // requester 1
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   input  logic             r1_sub,
   // response 0
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_sum,
   output logic             rsp0_ovf,
   output logic             rsp0_cout,
   // response 1
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_sum,
   output logic             rsp1_ovf,
   output logic             rsp1_cout,
   // shared adder
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_ovf,
   input  logic             add_cout,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESP    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             sub_q, sub_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic             cout_q, cout_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;

   logic [1:0]       gnt;
   logic [1:0]       rsp_ready_v;

   assign rsp_ready_v = {rsp1_ready, rsp0_ready};

   // Grant is only evaluated in IDLE, so ready is implicitly low while busy.
   generate
      if (PRIO_MODE) begin : g_fixed
         always_comb begin
            gnt = 2'b00;
            if (state_q == IDLE) begin
               gnt[0] = r0_valid;
               gnt[1] = r1_valid & ~r0_valid;
            end
         end
      end else begin : g_rr
         always_comb begin
            gnt = 2'b00;
            if (state_q == IDLE) begin
               gnt[0] = r0_valid & (~r1_valid | ~ptr_q);
               gnt[1] = r1_valid & (~r0_valid |  ptr_q);
            end
         end
      end
   endgenerate

   assign r0_ready = gnt[0];
   assign r1_ready = gnt[1];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      sub_d       = sub_q;
      sum_d       = sum_q;
      ovf_d       = ovf_q;
      cout_d      = cout_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               owner_d = gnt[1];
               opa_d   = gnt[1] ? r1_a : r0_a;
               sub_d   = gnt[1] ? r1_sub : r0_sub;
               // B is stored pre-inverted so the COMPUTE cycle drives it straight out.
               if (gnt[1]) opb_d = r1_sub ? ~r1_b : r1_b;
               else        opb_d = r0_sub ? ~r0_b : r0_b;
               if (!PRIO_MODE) ptr_d = ~gnt[1];
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            sum_d       = add_s;
            ovf_d       = add_ovf;
            cout_d      = add_cout;
            rsp_valid_d = owner_q ? 2'b10 : 2'b01;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_v[owner_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = IDLE;
            end
         end
         default: begin
            rsp_valid_d = 2'b00;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         opa_q       <= '0;
         opb_q       <= '0;
         sub_q       <= 1'b0;
         sum_q       <= '0;
         ovf_q       <= 1'b0;
         cout_q      <= 1'b0;
         rsp_valid_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         sub_q       <= sub_d;
         sum_q       <= sum_d;
         ovf_q       <= ovf_d;
         cout_q      <= cout_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Adder inputs are quiet outside COMPUTE to avoid needless toggling.
   assign add_a   = (state_q == COMPUTE) ? opa_q : '0;
   assign add_b   = (state_q == COMPUTE) ? opb_q : '0;
   assign add_cin = (state_q == COMPUTE) ? sub_q : 1'b0;

   assign rsp0_valid = rsp_valid_q[0];
   assign rsp0_sum   = sum_q;
   assign rsp0_ovf   = ovf_q;
   assign rsp0_cout  = cout_q;
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp1_sum   = sum_q;
   assign rsp1_ovf   = ovf_q;
   assign rsp1_cout  = cout_q;

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ppa_share_arb.sv
// Directed bench for ppa_share_arb: one round-robin and one fixed-priority instance
// share the requester stimulus, each with its own behavioural adder.
module tb_ppa_share_arb;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        r0_valid, r0_sub, r1_valid, r1_sub;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic        rsp0_ready, rsp1_ready;

   // round-robin instance outputs
   logic        r0_ready, r1_ready, rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_sum, rsp1_sum;
   logic        rsp0_ovf, rsp0_cout, rsp1_ovf, rsp1_cout;
   logic [31:0] add_a, add_b, add_s;
   logic        add_cin, add_ovf, add_cout, busy;

   // fixed-priority instance outputs
   logic        p_r0_ready, p_r1_ready, p_rsp0_valid, p_rsp1_valid;
   logic [31:0] p_rsp0_sum, p_rsp1_sum;
   logic        p_rsp0_ovf, p_rsp0_cout, p_rsp1_ovf, p_rsp1_cout;
   logic [31:0] p_add_a, p_add_b, p_add_s;
   logic        p_add_cin, p_add_ovf, p_add_cout, p_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
   assign add_ovf = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
   assign {p_add_cout, p_add_s} = {1'b0, p_add_a} + {1'b0, p_add_b} + {32'd0, p_add_cin};
   assign p_add_ovf = (p_add_a[31] == p_add_b[31]) && (p_add_s[31] != p_add_a[31]);

   ppa_share_arb #(.WIDTH(32), .PRIO_MODE(1'b0)) u_rr (
      .clock(clock), .reset_n(reset_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum),
      .rsp0_ovf(rsp0_ovf), .rsp0_cout(rsp0_cout),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum),
      .rsp1_ovf(rsp1_ovf), .rsp1_cout(rsp1_cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_ovf(add_ovf), .add_cout(add_cout), .busy(busy)
   );

   ppa_share_arb #(.WIDTH(32), .PRIO_MODE(1'b1)) u_fp (
      .clock(clock), .reset_n(reset_n),
      .r0_valid(r0_valid), .r0_ready(p_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
      .r1_valid(r1_valid), .r1_ready(p_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
      .rsp0_valid(p_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(p_rsp0_sum),
      .rsp0_ovf(p_rsp0_ovf), .rsp0_cout(p_rsp0_cout),
      .rsp1_valid(p_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(p_rsp1_sum),
      .rsp1_ovf(p_rsp1_ovf), .rsp1_cout(p_rsp1_cout),
      .add_a(p_add_a), .add_b(p_add_b), .add_cin(p_add_cin),
      .add_s(p_add_s), .add_ovf(p_add_ovf), .add_cout(p_add_cout), .busy(p_busy)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One full single-requester transaction on the round-robin instance.
   task automatic op(input bit req, input logic [31:0] a, input logic [31:0] b, input bit sub,
                     input logic [31:0] eb, input logic [31:0] es, input bit eo, input bit ec,
                     input string nm);
      @(negedge clock);
      if (req) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_sub = sub; end
      else     begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_sub = sub; end
      #1;
      check1({nm, " ready"}, req ? r1_ready : r0_ready, 1'b1);
      check1({nm, " other ready"}, req ? r0_ready : r1_ready, 1'b0);
      @(posedge clock);
      #1;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      @(negedge clock);
      check32({nm, " add_a"}, add_a, a);
      check32({nm, " add_b"}, add_b, eb);
      check1({nm, " add_cin"}, add_cin, sub);
      check1({nm, " busy"}, busy, 1'b1);
      check1({nm, " early rsp"}, req ? rsp1_valid : rsp0_valid, 1'b0);
      @(negedge clock);
      check1({nm, " rsp_valid"}, req ? rsp1_valid : rsp0_valid, 1'b1);
      check1({nm, " other rsp_valid"}, req ? rsp0_valid : rsp1_valid, 1'b0);
      check32({nm, " sum"}, req ? rsp1_sum : rsp0_sum, es);
      check1({nm, " ovf"}, req ? rsp1_ovf : rsp0_ovf, eo);
      check1({nm, " cout"}, req ? rsp1_cout : rsp0_cout, ec);
      if (req) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      @(negedge clock);
      check1({nm, " rsp drop"}, req ? rsp1_valid : rsp0_valid, 1'b0);
      check1({nm, " idle"}, busy, 1'b0);
      $display("txn %s: req%0d a=%08h b=%08h sub=%0d sum=%08h ovf=%0d cout=%0d",
               nm, req, a, b, sub, es, eo, ec);
   endtask

   initial begin
      reset_n = 1'b0;
      r0_valid = 1'b0; r0_sub = 1'b0; r0_a = '0; r0_b = '0;
      r1_valid = 1'b0; r1_sub = 1'b0; r1_a = '0; r1_b = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // reset state
      @(negedge clock);
      check1("rst busy", busy, 1'b0);
      check1("rst r0_ready", r0_ready, 1'b0);
      check1("rst rsp0_valid", rsp0_valid, 1'b0);
      check1("rst rsp1_valid", rsp1_valid, 1'b0);
      check32("rst rsp0_sum", rsp0_sum, 32'h0);
      check32("rst add_a", add_a, 32'h0);
      check32("rst add_b", add_b, 32'h0);
      check1("rst add_cin", add_cin, 1'b0);
      check1("rst p_busy", p_busy, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;

      // single-requester arithmetic
      op(1'b0, 32'd5,        32'd7, 1'b0, 32'd7,        32'd12,       1'b0, 1'b0, "add5p7");
      op(1'b1, 32'd3,        32'd5, 1'b1, 32'hFFFFFFFA, 32'hFFFFFFFE, 1'b0, 1'b0, "sub3m5");
      op(1'b1, 32'h80000000, 32'd1, 1'b1, 32'hFFFFFFFE, 32'h7FFFFFFF, 1'b1, 1'b1, "subminm1");
      op(1'b0, 32'h7FFFFFFF, 32'd1, 1'b0, 32'd1,        32'h80000000, 1'b1, 1'b0, "addmaxp1");
      op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd1,        32'h0,        1'b0, 1'b1, "addallp1");

      // arbitration, both valid, responses always consumed
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd2; r0_sub = 1'b0;
      r1_valid = 1'b1; r1_a = 32'd3; r1_b = 32'd4; r1_sub = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         check1("rr r0_ready", r0_ready, (k % 3 == 0) && ((k / 3) % 2 == 0));
         check1("rr r1_ready", r1_ready, (k % 3 == 0) && ((k / 3) % 2 == 1));
         check1("fp r0_ready", p_r0_ready, (k % 3 == 0));
         check1("fp r1_ready", p_r1_ready, 1'b0);
         if (k % 3 == 0)
            $display("arb cycle %0d: rr grant r0=%0d r1=%0d, fp grant r0=%0d r1=%0d",
                     k, r0_ready, r1_ready, p_r0_ready, p_r1_ready);
         @(negedge clock);
      end
      reset_n = 1'b0;
      r0_valid = 1'b0; r1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // response stall with r1 waiting
      @(negedge clock);
      reset_n = 1'b1;
      r0_valid = 1'b1; r0_a = 32'd10;  r0_b = 32'd20; r0_sub = 1'b0;
      r1_valid = 1'b1; r1_a = 32'd100; r1_b = 32'd1;  r1_sub = 1'b0;
      #1;
      check1("stall r0_ready", r0_ready, 1'b1);
      check1("stall r1_ready", r1_ready, 1'b0);
      @(posedge clock);
      #1;
      r0_valid = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check1("stall rsp0_valid", rsp0_valid, 1'b1);
         check32("stall rsp0_sum", rsp0_sum, 32'd30);
         check1("stall r1_ready", r1_ready, 1'b0);
         check1("stall busy", busy, 1'b1);
      end
      rsp0_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp0_ready = 1'b0;
      @(negedge clock);
      check1("post stall rsp0_valid", rsp0_valid, 1'b0);
      check1("post stall r1_ready", r1_ready, 1'b1);
      check1("post stall r0_ready", r0_ready, 1'b0);
      check1("post stall busy", busy, 1'b0);
      $display("txn stall: req0 10+20 held 10 cycles, then r1 granted");
      rsp1_ready = 1'b1;
      @(posedge clock);
      #1;
      r1_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check1("r1 after stall rsp1_valid", rsp1_valid, 1'b1);
      check32("r1 after stall sum", rsp1_sum, 32'd101);
      @(posedge clock);
      #1;
      rsp1_ready = 1'b0;
      @(negedge clock);
      check1("r1 after stall idle", busy, 1'b0);
      $display("txn r1: 100+1 sum=%08h", 32'd101);

      // reset during COMPUTE
      r0_valid = 1'b1; r0_a = 32'h1234; r0_b = 32'd1; r0_sub = 1'b1;
      #1;
      check1("mid r0_ready", r0_ready, 1'b1);
      @(posedge clock);
      #1;
      r0_valid = 1'b0;
      @(negedge clock);
      check1("mid busy", busy, 1'b1);
      check32("mid add_b", add_b, 32'hFFFFFFFE);
      reset_n = 1'b0;
      #1;
      check1("mid rst busy", busy, 1'b0);
      check32("mid rst add_a", add_a, 32'h0);
      check32("mid rst add_b", add_b, 32'h0);
      check1("mid rst add_cin", add_cin, 1'b0);
      check1("mid rst rsp0_valid", rsp0_valid, 1'b0);
      check1("mid rst p_busy", p_busy, 1'b0);
      @(negedge clock);
      check1("mid rst no rsp", rsp0_valid, 1'b0);
      check32("mid rst rsp0_sum", rsp0_sum, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      r0_valid = 1'b1; r1_valid = 1'b1;
      #1;
      check1("after rst r0_ready", r0_ready, 1'b1);
      check1("after rst r1_ready", r1_ready, 1'b0);
      $display("txn reset: op discarded, requester 0 granted after release");
      @(negedge clock);
      r0_valid = 1'b0; r1_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
